// File: rtl/wb_pkg.sv
// Shared definitions for the Wishbone register-bank responder and the bridge benches:
// FSM encoding, fixed register indices and the byte-lane merge helper.
package wb_pkg;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_ACK  = 2'd2,
    S_ERR  = 2'd3
  } wb_state_t;

  localparam int unsigned REG_ID    = 32'd0;
  localparam int unsigned REG_COUNT = 32'd1;
  localparam int unsigned REG_CTRL  = 32'd2;

  // Byte n of the result comes from new_word when sel[n] is set, else from old_word.
  function automatic logic [31:0] merge_bytes(
    input logic [31:0] old_word,
    input logic [31:0] new_word,
    input logic [3:0]  sel
  );
    logic [31:0] merged;
    for (int i = 0; i < 4; i++) begin
      merged[8*i +: 8] = sel[i] ? new_word[8*i +: 8] : old_word[8*i +: 8];
    end
    return merged;
  endfunction

endpackage

// File: rtl/wb_byte_lane_reg.sv
// 32-bit register with per-byte write enables; one instance backs each read/write word.
module wb_byte_lane_reg
  import wb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  be,
  input  logic [31:0] d,
  output logic [31:0] q
);

  // Selected byte lanes take the new data, the others hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      q <= 32'h0000_0000;
    end else begin
      q <= merge_bytes(q, d, be);
    end
  end

endmodule

// File: rtl/wishbone_regbank_responder.sv
// Wishbone classic responder: ID word, free-running counter word and byte-writable words,
// with fixed wait states and exactly one registered ack or err per accepted request.
module wishbone_regbank_responder
  import wb_pkg::*;
#(
  parameter int          ADR_WIDTH   = 22,
  parameter int          NUM_REGS    = 16,
  parameter int          WAIT_STATES = 1,
  parameter logic [31:0] ID_VALUE    = 32'h4550_0001,
  // Counter value after reset; stays zero except where a bench needs to reach the wrap quickly.
  parameter logic [31:0] COUNT_INIT  = 32'h0000_0000
) (
  input  logic                 in_clock,
  input  logic                 in_reset_n,
  input  logic                 in_wb_cyc,
  input  logic                 in_wb_stb,
  input  logic                 in_wb_we,
  input  logic [ADR_WIDTH-1:0] in_wb_adr,
  input  logic [3:0]           in_wb_sel,
  input  logic [31:0]          in_wb_wdat,
  output logic                 out_wb_ack,
  output logic                 out_wb_err,
  output logic [31:0]          out_wb_rdat,
  output logic [31:0]          out_ctrl
);

  localparam logic [3:0]           WAIT_LOAD    = 4'(WAIT_STATES);
  localparam logic [ADR_WIDTH-1:0] NUM_REGS_ADR = ADR_WIDTH'(NUM_REGS);
  localparam logic [ADR_WIDTH-1:0] LAST_RO_ADR  = ADR_WIDTH'(REG_COUNT);

  wb_state_t              state_r, state_s;
  logic [3:0]             wait_r, wait_s;
  logic                   capture_s, term_s;
  logic                   cap_we_r;
  logic [ADR_WIDTH-1:0]   cap_adr_r;
  logic [3:0]             cap_sel_r;
  logic [31:0]            cap_wdat_r;
  logic [31:0]            count_r;
  logic                   ack_r, err_r;
  logic [31:0]            rdat_r;
  logic                   req_we_s;
  logic [ADR_WIDTH-1:0]   req_adr_s;
  logic [3:0]             req_sel_s;
  logic [31:0]            req_wdat_s;
  logic                   is_err_s, wr_en_s;
  logic [31:0]            rd_word_s;
  logic [31:0]            word_s [NUM_REGS];

  // With no wait states the request terminates on its capture edge, so decode the live bus then.
  assign req_we_s   = (state_r == S_IDLE) ? in_wb_we   : cap_we_r;
  assign req_adr_s  = (state_r == S_IDLE) ? in_wb_adr  : cap_adr_r;
  assign req_sel_s  = (state_r == S_IDLE) ? in_wb_sel  : cap_sel_r;
  assign req_wdat_s = (state_r == S_IDLE) ? in_wb_wdat : cap_wdat_r;

  assign is_err_s = (req_adr_s >= NUM_REGS_ADR) || (req_we_s && (req_adr_s <= LAST_RO_ADR));
  assign wr_en_s  = term_s && !is_err_s && req_we_s;

  assign word_s[REG_ID]    = ID_VALUE;
  assign word_s[REG_COUNT] = count_r;

  for (genvar i = REG_CTRL; i < NUM_REGS; i++) begin : g_rw
    logic [3:0] be_s;
    assign be_s = (wr_en_s && (req_adr_s == ADR_WIDTH'(i))) ? req_sel_s : 4'b0000;
    wb_byte_lane_reg u_word (
      .clk   (in_clock),
      .rst_n (in_reset_n),
      .be    (be_s),
      .d     (req_wdat_s),
      .q     (word_s[i])
    );
  end

  assign out_ctrl = word_s[REG_CTRL];

  // Full-address compare, so out-of-range addresses never alias onto a real word.
  always_comb begin
    rd_word_s = 32'h0000_0000;
    for (int i = 0; i < NUM_REGS; i++) begin
      rd_word_s = (req_adr_s == ADR_WIDTH'(i)) ? word_s[i] : rd_word_s;
    end
  end

  // Next-state logic: accept in IDLE, count down wait states, abort if cyc drops.
  always_comb begin
    state_s   = state_r;
    wait_s    = wait_r;
    capture_s = 1'b0;
    term_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (in_wb_cyc && in_wb_stb) begin
          capture_s = 1'b1;
          if (WAIT_STATES > 0) begin
            state_s = S_WAIT;
            wait_s  = WAIT_LOAD;
          end else begin
            term_s  = 1'b1;
            state_s = is_err_s ? S_ERR : S_ACK;
          end
        end else begin
          state_s = S_IDLE;
        end
      end
      S_WAIT: begin
        if (!in_wb_cyc) begin
          state_s = S_IDLE;
          wait_s  = 4'd0;
        end else if (wait_r <= 4'd1) begin
          term_s  = 1'b1;
          wait_s  = 4'd0;
          state_s = is_err_s ? S_ERR : S_ACK;
        end else begin
          wait_s  = wait_r - 4'd1;
        end
      end
      S_ACK, S_ERR: state_s = S_IDLE;
      default:      state_s = S_IDLE;
    endcase
  end

  // State, capture, counter and registered bus responses.
  always_ff @(posedge in_clock or negedge in_reset_n) begin
    if (!in_reset_n) begin
      state_r    <= S_IDLE;
      wait_r     <= 4'd0;
      cap_we_r   <= 1'b0;
      cap_adr_r  <= '0;
      cap_sel_r  <= 4'b0000;
      cap_wdat_r <= 32'h0000_0000;
      count_r    <= COUNT_INIT;
      ack_r      <= 1'b0;
      err_r      <= 1'b0;
      rdat_r     <= 32'h0000_0000;
    end else begin
      state_r <= state_s;
      wait_r  <= wait_s;
      count_r <= count_r + 32'd1;
      ack_r   <= term_s && !is_err_s;
      err_r   <= term_s && is_err_s;
      if (capture_s) begin
        cap_we_r   <= in_wb_we;
        cap_adr_r  <= in_wb_adr;
        cap_sel_r  <= in_wb_sel;
        cap_wdat_r <= in_wb_wdat;
      end
      if (term_s && is_err_s) begin
        rdat_r <= 32'h0000_0000;
      end else if (term_s && !req_we_s) begin
        rdat_r <= rd_word_s;
      end
    end
  end

  assign out_wb_ack  = ack_r;
  assign out_wb_err  = err_r;
  assign out_wb_rdat = rdat_r;

endmodule

// File: tb/tb_wishbone_regbank_responder.sv
// Bench for wishbone_regbank_responder: a transaction-level model checked every cycle on a
// one-wait-state instance, plus directed checks on a three-wait-state instance near the counter wrap.
module tb_wishbone_regbank_responder;

  localparam int          NR      = 16;
  localparam logic [31:0] ID      = 32'h4550_0001;
  localparam logic [31:0] B_CINIT = 32'hFFFF_FFFA;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        a_rst_n = 1'b0, a_cyc = 1'b0, a_stb = 1'b0, a_we = 1'b0;
  logic [21:0] a_adr = 22'd0;
  logic [3:0]  a_sel = 4'd0;
  logic [31:0] a_wdat = 32'd0;
  logic        a_ack, a_err;
  logic [31:0] a_rdat, a_ctrl;

  logic        b_rst_n = 1'b0, b_cyc = 1'b0, b_stb = 1'b0, b_we = 1'b0;
  logic [21:0] b_adr = 22'd0;
  logic [3:0]  b_sel = 4'd0;
  logic [31:0] b_wdat = 32'd0;
  logic        b_ack, b_err;
  logic [31:0] b_rdat, b_ctrl;

  wishbone_regbank_responder #(.WAIT_STATES(1)) dut_a (
    .in_clock(clk), .in_reset_n(a_rst_n), .in_wb_cyc(a_cyc), .in_wb_stb(a_stb),
    .in_wb_we(a_we), .in_wb_adr(a_adr), .in_wb_sel(a_sel), .in_wb_wdat(a_wdat),
    .out_wb_ack(a_ack), .out_wb_err(a_err), .out_wb_rdat(a_rdat), .out_ctrl(a_ctrl)
  );

  wishbone_regbank_responder #(.WAIT_STATES(3), .COUNT_INIT(B_CINIT)) dut_b (
    .in_clock(clk), .in_reset_n(b_rst_n), .in_wb_cyc(b_cyc), .in_wb_stb(b_stb),
    .in_wb_we(b_we), .in_wb_adr(b_adr), .in_wb_sel(b_sel), .in_wb_wdat(b_wdat),
    .out_wb_ack(b_ack), .out_wb_err(b_err), .out_wb_rdat(b_rdat), .out_ctrl(b_ctrl)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model of instance A: words, counter, and the edge on which each response lands.
  logic [31:0] m_regs [NR];
  logic [31:0] m_count = 32'd0, m_rdat = 32'd0, m_wdat = 32'd0;
  logic [3:0]  m_sel = 4'd0;
  bit          m_pend = 1'b0, m_we = 1'b0, exp_ack = 1'b0, exp_err = 1'b0;
  int          m_adr = 0, m_edge = 0, m_term = 0, m_idle_at = 0, m_acks = 0, a_acks_seen = 0;

  initial begin
    for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
    forever begin
      @(posedge clk or negedge a_rst_n);
      if (!a_rst_n) begin
        for (int i = 0; i < NR; i++) m_regs[i] = 32'd0;
        m_count = 32'd0; m_rdat = 32'd0; m_pend = 1'b0;
        m_edge = 0; m_idle_at = 0; exp_ack = 1'b0; exp_err = 1'b0;
      end else begin
        m_edge++;
        exp_ack = 1'b0;
        exp_err = 1'b0;
        if (!m_pend && m_edge >= m_idle_at && a_cyc && a_stb) begin
          m_pend = 1'b1; m_we = a_we; m_adr = int'(a_adr); m_sel = a_sel; m_wdat = a_wdat;
          m_term = m_edge + 1;
        end
        if (m_pend && m_edge == m_term) begin
          m_pend    = 1'b0;
          m_idle_at = m_edge + 2;
          if (m_adr >= NR || (m_we && m_adr < 2)) begin
            exp_err = 1'b1;
            m_rdat  = 32'd0;
          end else begin
            exp_ack = 1'b1;
            m_acks++;
            if (m_we) begin
              for (int b = 0; b < 4; b++)
                if (m_sel[b]) m_regs[m_adr][8*b +: 8] = m_wdat[8*b +: 8];
            end else begin
              m_rdat = (m_adr == 0) ? ID : (m_adr == 1) ? m_count : m_regs[m_adr];
            end
          end
        end
        m_count = m_count + 32'd1;
      end
    end
  end

  // Every cycle, instance A's outputs must equal the model's.
  initial forever begin
    @(negedge clk);
    check("a_ack", 32'(a_ack), 32'(exp_ack));
    check("a_err", 32'(a_err), 32'(exp_err));
    check("a_rdat", a_rdat, m_rdat);
    check("a_ctrl", a_ctrl, m_regs[2]);
    if (a_ack) a_acks_seen++;
  end

  int b_edge = 0;
  initial forever begin
    @(posedge clk or negedge b_rst_n);
    if (!b_rst_n) b_edge = 0;
    else          b_edge++;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  bit          t_ack, t_err;
  logic [31:0] t_rdat, r1, r2;
  int          t_lat, t_edge, e1, e2, seen;

  task automatic drive(input bit on_b, input bit act, input bit we, input int adr,
                       input logic [3:0] sel, input logic [31:0] wdat);
    if (on_b) begin
      b_cyc = act; b_stb = act; b_we = we; b_adr = 22'(adr); b_sel = sel; b_wdat = wdat;
    end else begin
      a_cyc = act; a_stb = act; a_we = we; a_adr = 22'(adr); a_sel = sel; a_wdat = wdat;
    end
  endtask

  // One transfer, started at a negedge; stb is held through the cycle after the response.
  task automatic xfer(input bit on_b, input bit we, input int adr,
                      input logic [3:0] sel, input logic [31:0] wdat);
    drive(on_b, 1'b1, we, adr, sel, wdat);
    @(posedge clk);
    t_lat = 0; t_ack = 1'b0; t_err = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (on_b ? (b_ack || b_err) : (a_ack || a_err)) begin
        t_ack  = on_b ? b_ack : a_ack;
        t_err  = on_b ? b_err : a_err;
        t_rdat = on_b ? b_rdat : a_rdat;
        t_edge = b_edge;
        break;
      end
      t_lat++;
    end
    if (!t_ack && !t_err) check("xfer_timeout", 32'd0, 32'd1);
    @(negedge clk);
    check("no_dup_response", 32'(on_b ? (b_ack || b_err) : (a_ack || a_err)), 32'd0);
    drive(on_b, 1'b0, 1'b0, 0, 4'h0, 32'd0);
  endtask

  initial begin
    #12;
    check("rst_a_ack", 32'(a_ack), 32'd0);
    check("rst_a_err", 32'(a_err), 32'd0);
    check("rst_a_rdat", a_rdat, 32'd0);
    check("rst_a_ctrl", a_ctrl, 32'd0);
    @(negedge clk);
    a_rst_n = 1'b1;
    b_rst_n = 1'b1;

    // B: two counter reads straddling the wrap.
    xfer(1'b1, 1'b0, 1, 4'hF, 32'd0);
    r1 = t_rdat; e1 = t_edge;
    check("b_cnt1_ack", 32'(t_ack), 32'd1);
    check("b_cnt1_lat", 32'(t_lat), 32'd3);
    check("b_cnt1_val", r1, B_CINIT + 32'(e1 - 1));
    check("b_cnt1_pin", r1, 32'hFFFF_FFFD);
    xfer(1'b1, 1'b0, 1, 4'h0, 32'd0);
    r2 = t_rdat; e2 = t_edge;
    check("b_cnt2_val", r2, B_CINIT + 32'(e2 - 1));
    check("b_cnt2_pin", r2, 32'h0000_0002);
    check("b_cnt_delta", r2 - r1, 32'(e2 - e1));

    xfer(1'b1, 1'b1, 2, 4'hF, 32'hCAFE_F00D);
    check("b_wr2_ack", 32'(t_ack), 32'd1);
    check("b_ctrl", b_ctrl, 32'hCAFE_F00D);

    // B: cyc dropped while waiting must leave no trace.
    drive(1'b1, 1'b1, 1'b1, 3, 4'hF, 32'hFFFF_FFFF);
    @(posedge clk);
    @(negedge clk);
    @(negedge clk);
    drive(1'b1, 1'b0, 1'b0, 0, 4'h0, 32'd0);
    seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (b_ack || b_err) seen++;
    end
    check("b_abort_silent", 32'(seen), 32'd0);

    // B: asynchronous reset in the middle of a write wait.
    drive(1'b1, 1'b1, 1'b1, 2, 4'hF, 32'h1234_5678);
    @(posedge clk);
    @(negedge clk);
    #2 b_rst_n = 1'b0;
    #1;
    check("b_rst_ack", 32'(b_ack), 32'd0);
    check("b_rst_err", 32'(b_err), 32'd0);
    check("b_rst_rdat", b_rdat, 32'd0);
    check("b_rst_ctrl", b_ctrl, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 0, 4'h0, 32'd0);
    @(negedge clk);
    b_rst_n = 1'b1;
    xfer(1'b1, 1'b0, 3, 4'hF, 32'd0);
    check("b_rd3_ack", 32'(t_ack), 32'd1);
    check("b_rd3_val", t_rdat, 32'd0);
    xfer(1'b1, 1'b0, 2, 4'hF, 32'd0);
    check("b_rd2_val", t_rdat, 32'd0);

    // A: main register-bank behaviour, checked by the model every cycle plus pinned values.
    xfer(1'b0, 1'b0, 0, 4'hF, 32'd0);
    check("a_id_ack", 32'(t_ack), 32'd1);
    check("a_id_err", 32'(t_err), 32'd0);
    check("a_id_lat", 32'(t_lat), 32'd1);
    check("a_id_val", t_rdat, 32'h4550_0001);
    xfer(1'b0, 1'b1, 2, 4'hF, 32'hDEAD_BEEF);
    check("a_wr2_ack", 32'(t_ack), 32'd1);
    check("a_ctrl_pin", a_ctrl, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b0, 2, 4'hF, 32'd0);
    check("a_rd2_pin", t_rdat, 32'hDEAD_BEEF);
    xfer(1'b0, 1'b1, 2, 4'b0101, 32'h1122_3344);
    xfer(1'b0, 1'b0, 2, 4'h0, 32'd0);
    check("a_partial_pin", t_rdat, 32'hDE22_BE44);
    xfer(1'b0, 1'b1, 1, 4'hF, 32'h0);
    check("a_wr_cnt_err", 32'(t_err), 32'd1);
    check("a_wr_cnt_ack", 32'(t_ack), 32'd0);
    xfer(1'b0, 1'b0, 1, 4'hF, 32'd0);
    xfer(1'b0, 1'b0, 1, 4'hF, 32'd0);
    xfer(1'b0, 1'b0, 16, 4'hF, 32'd0);
    check("a_oor_err", 32'(t_err), 32'd1);
    check("a_oor_rdat", t_rdat, 32'd0);
    xfer(1'b0, 1'b0, 22'h10_0002, 4'hF, 32'd0);
    check("a_alias_err", 32'(t_err), 32'd1);
    xfer(1'b0, 1'b0, 255, 4'hF, 32'd0);
    xfer(1'b0, 1'b1, 0, 4'hF, 32'h0BAD_0BAD);
    check("a_wr_id_err", 32'(t_err), 32'd1);
    xfer(1'b0, 1'b0, 0, 4'hF, 32'd0);
    check("a_id_kept", t_rdat, 32'h4550_0001);
    xfer(1'b0, 1'b1, 15, 4'h0, 32'hFFFF_FFFF);
    check("a_sel0_ack", 32'(t_ack), 32'd1);
    xfer(1'b0, 1'b0, 15, 4'hF, 32'd0);
    check("a_sel0_val", t_rdat, 32'd0);
    xfer(1'b0, 1'b1, 15, 4'hF, 32'hA5A5_5A5A);
    xfer(1'b0, 1'b0, 15, 4'hF, 32'd0);
    check("a_rd15_pin", t_rdat, 32'hA5A5_5A5A);
    xfer(1'b0, 1'b0, 3, 4'hF, 32'd0);
    @(negedge clk);
    check("a_ack_count", 32'(a_acks_seen), 32'(m_acks));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
